// File: rtl/count_monitor.sv
// Sequence monitor for a free-running up-counter: tracks lock, errors, restarts and run length.
// Optional macro COUNT_MON_MAXRUN_EN enables the max_run register; otherwise max_run is tied to 0.
module count_monitor #(
   parameter int WIDTH    = 16,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8,
   parameter int RUN_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   output logic             locked,
   output logic             err,
   output logic             restart,
   output logic [ERR_W-1:0] err_cnt,
   output logic [RUN_W-1:0] run_len,
   output logic [RUN_W-1:0] max_run
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] inc;
   logic [3:0]       match, match_nxt;
   logic             err_nxt, restart_nxt;
   logic [ERR_W-1:0] err_cnt_nxt;
   logic [RUN_W-1:0] run_len_nxt;
   logic             good, rst_edge, rst_hold;

   function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
      return (&v) ? v : v + RUN_W'(1);
   endfunction

   // The all-ones -> 0 wrap counts as good, so it is excluded from rst_edge.
   assign inc      = prev + WIDTH'(1);
   assign good     = (count == inc);
   assign rst_edge = (count == '0) && (prev != '0) && !good;
   assign rst_hold = (count == '0) && (prev == '0);

   always_comb begin
      state_nxt   = state;
      match_nxt   = match;
      err_nxt     = 1'b0;
      restart_nxt = 1'b0;
      err_cnt_nxt = err_cnt;
      run_len_nxt = run_len;
      if (en) begin
         case (state)
            IDLE: begin
               state_nxt = ACQUIRE;
               match_nxt = '0;
            end
            ACQUIRE: begin
               if (good) begin
                  match_nxt = match + 4'd1;
                  if (match + 4'd1 == LOCK_V) begin
                     state_nxt   = LOCKED;
                     run_len_nxt = '0;
                  end
               end else begin
                  match_nxt = '0;
               end
            end
            LOCKED: begin
               if (good) begin
                  run_len_nxt = sat_run(run_len);
               end else if (rst_edge) begin
                  restart_nxt = 1'b1;
                  run_len_nxt = '0;
               end else if (!rst_hold) begin
                  err_nxt     = 1'b1;
                  err_cnt_nxt = sat_err(err_cnt);
                  run_len_nxt = '0;
                  match_nxt   = '0;
                  state_nxt   = ACQUIRE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prev    <= '0;
         match   <= '0;
         err     <= 1'b0;
         restart <= 1'b0;
         err_cnt <= '0;
         run_len <= '0;
      end else begin
         state   <= state_nxt;
         match   <= match_nxt;
         err     <= err_nxt;
         restart <= restart_nxt;
         err_cnt <= err_cnt_nxt;
         run_len <= run_len_nxt;
         if (en) prev <= count;
      end
   end

   assign locked = (state == LOCKED);

`ifdef COUNT_MON_MAXRUN_EN
   logic [RUN_W-1:0] max_run_q;

   // Captures the run length that is about to be discarded by a restart or error.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_run_q <= '0;
      end else if ((err_nxt || restart_nxt) && (run_len > max_run_q)) begin
         max_run_q <= run_len;
      end
   end

   assign max_run = max_run_q;
`else
   assign max_run = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: directed steps push expected outputs, a monitor pops and compares.
module tb_count_monitor;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] count;
   logic        locked, err, restart;
   logic [1:0]  err_cnt;
   logic [4:0]  run_len;
   logic [4:0]  max_run;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string      name;
      logic       l;
      logic       e;
      logic       r;
      logic [1:0] ec;
      logic [4:0] rl;
      logic [4:0] mr;
   } exp_t;

   exp_t q[$];

   count_monitor #(.WIDTH(16), .LOCK_CNT(4), .ERR_W(2), .RUN_W(5)) dut (
      .clk(clk), .rst(rst), .en(en), .count(count),
      .locked(locked), .err(err), .restart(restart),
      .err_cnt(err_cnt), .run_len(run_len), .max_run(max_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input string nm, input logic r, input logic e, input logic [15:0] c,
                       input logic l, input logic er, input logic rs,
                       input int ec, input int rl, input int mr);
      exp_t x;
      @(negedge clk);
      rst   = r;
      en    = e;
      count = c;
      x.name = nm;
      x.l  = l;
      x.e  = er;
      x.r  = rs;
      x.ec = 2'(ec);
      x.rl = 5'(rl);
`ifdef COUNT_MON_MAXRUN_EN
      x.mr = 5'(mr);
`else
      x.mr = 5'(mr & 0);
`endif
      q.push_back(x);
   endtask

   // Monitor: every stepped cycle presents a registered response just after the next edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            tests_run++;
            if ({locked, err, restart, err_cnt, run_len, max_run} !== {x.l, x.e, x.r, x.ec, x.rl, x.mr}) begin
               tests_failed++;
               $display("FAIL %s: got L=%0b E=%0b R=%0b ec=%0d rl=%0d mr=%0d, want L=%0b E=%0b R=%0b ec=%0d rl=%0d mr=%0d",
                        x.name, locked, err, restart, err_cnt, run_len, max_run,
                        x.l, x.e, x.r, x.ec, x.rl, x.mr);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      en = 1'b0;
      count = '0;

      // initial lock from 0
      step("reset0", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("reset1", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("idle_load", 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("acq", 0, 1, 16'(i), 0, 0, 0, 0, 0, 0);
      step("lock_at4", 0, 1, 16'h0004, 1, 0, 0, 0, 0, 0);
      step("run5", 0, 1, 16'h0005, 1, 0, 0, 0, 1, 0);

      // wrap through all-ones
      step("rst_wrap", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("wrap_idle", 0, 1, 16'hFFFA, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("wrap_acq", 0, 1, 16'hFFFA + 16'(i), 0, 0, 0, 0, 0, 0);
      step("wrap_lock", 0, 1, 16'hFFFE, 1, 0, 0, 0, 0, 0);
      step("wrap_ffff", 0, 1, 16'hFFFF, 1, 0, 0, 0, 1, 0);
      step("wrap_0000", 0, 1, 16'h0000, 1, 0, 0, 0, 2, 0);
      step("wrap_0001", 0, 1, 16'h0001, 1, 0, 0, 0, 3, 0);

      // single-sample producer reset
      step("rst_r1", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("r1_idle", 0, 1, 16'h0033, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("r1_acq", 0, 1, 16'h0033 + 16'(i), 0, 0, 0, 0, 0, 0);
      step("r1_lock37", 0, 1, 16'h0037, 1, 0, 0, 0, 0, 0);
      step("r1_restart", 0, 1, 16'h0000, 1, 0, 1, 0, 0, 0);
      step("r1_one", 0, 1, 16'h0001, 1, 0, 0, 0, 1, 0);
      step("r1_two", 0, 1, 16'h0002, 1, 0, 0, 0, 2, 0);

      // producer reset held for three samples
      step("rst_r3", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("r3_idle", 0, 1, 16'h0033, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("r3_acq", 0, 1, 16'h0033 + 16'(i), 0, 0, 0, 0, 0, 0);
      step("r3_lock37", 0, 1, 16'h0037, 1, 0, 0, 0, 0, 0);
      step("r3_run38", 0, 1, 16'h0038, 1, 0, 0, 0, 1, 0);
      step("r3_restart", 0, 1, 16'h0000, 1, 0, 1, 0, 0, 1);
      step("r3_hold1", 0, 1, 16'h0000, 1, 0, 0, 0, 0, 1);
      step("r3_hold2", 0, 1, 16'h0000, 1, 0, 0, 0, 0, 1);
      step("r3_one", 0, 1, 16'h0001, 1, 0, 0, 0, 1, 1);
      step("r3_two", 0, 1, 16'h0002, 1, 0, 0, 0, 2, 1);

      // sequence error and relock
      step("rst_err", 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      step("e_idle", 0, 1, 16'h000C, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("e_acq", 0, 1, 16'h000C + 16'(i), 0, 0, 0, 0, 0, 0);
      step("e_lock10", 0, 1, 16'h0010, 1, 0, 0, 0, 0, 0);
      step("e_skip12", 0, 1, 16'h0012, 0, 1, 0, 1, 0, 0);
      for (int i = 1; i <= 3; i++) step("e_reacq", 0, 1, 16'h0012 + 16'(i), 0, 0, 0, 1, 0, 0);
      step("e_relock", 0, 1, 16'h0016, 1, 0, 0, 1, 0, 0);
      step("e_run17", 0, 1, 16'h0017, 1, 0, 0, 1, 1, 0);

      // en gating
      step("en0_a", 0, 0, 16'h0099, 1, 0, 0, 1, 1, 0);
      step("en1_18", 0, 1, 16'h0018, 1, 0, 0, 1, 2, 0);
      step("en0_b", 0, 0, 16'h0055, 1, 0, 0, 1, 2, 0);
      step("en1_19", 0, 1, 16'h0019, 1, 0, 0, 1, 3, 0);
      step("en0_c", 0, 0, 16'h0000, 1, 0, 0, 1, 3, 0);
      step("en1_1a", 0, 1, 16'h001A, 1, 0, 0, 1, 4, 0);

      // more errors, acquire-time miss, err_cnt saturation
      step("err2", 0, 1, 16'h0030, 0, 1, 0, 2, 0, 4);
      step("acq31", 0, 1, 16'h0031, 0, 0, 0, 2, 0, 4);
      step("acq_miss", 0, 1, 16'h0050, 0, 0, 0, 2, 0, 4);
      for (int i = 1; i <= 3; i++) step("acq5x", 0, 1, 16'h0050 + 16'(i), 0, 0, 0, 2, 0, 4);
      step("lock54", 0, 1, 16'h0054, 1, 0, 0, 2, 0, 4);
      step("err3", 0, 1, 16'h0040, 0, 1, 0, 3, 0, 4);
      for (int i = 1; i <= 3; i++) step("acq4x", 0, 1, 16'h0040 + 16'(i), 0, 0, 0, 3, 0, 4);
      step("lock44", 0, 1, 16'h0044, 1, 0, 0, 3, 0, 4);
      step("run45", 0, 1, 16'h0045, 1, 0, 0, 3, 1, 4);
      step("err_sat", 0, 1, 16'h0047, 0, 1, 0, 3, 0, 4);
      for (int i = 1; i <= 3; i++) step("acq4y", 0, 1, 16'h0047 + 16'(i), 0, 0, 0, 3, 0, 4);
      step("lock4b", 0, 1, 16'h004B, 1, 0, 0, 3, 0, 4);
      step("run4c", 0, 1, 16'h004C, 1, 0, 0, 3, 1, 4);
      step("rst_mid", 1, 1, 16'h004D, 0, 0, 0, 0, 0, 0);
      step("post_rst", 0, 0, 16'h004E, 0, 0, 0, 0, 0, 0);

      // long run, max_run capture, run_len saturation
      step("m_idle", 0, 1, 16'h0100, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step("m_acq", 0, 1, 16'h0100 + 16'(i), 0, 0, 0, 0, 0, 0);
      step("m_lock", 0, 1, 16'h0104, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 20; i++) step("m_run", 0, 1, 16'h0104 + 16'(i), 1, 0, 0, 0, i, 0);
      step("m_restart", 0, 1, 16'h0000, 1, 0, 1, 0, 0, 20);
      for (int i = 1; i <= 35; i++) step("sat_run", 0, 1, 16'(i), 1, 0, 0, 0, (i > 31) ? 31 : i, 20);
      step("sat_err", 0, 1, 16'h0500, 0, 1, 0, 1, 0, 31);
      step("sat_hold", 0, 0, 16'h0501, 0, 0, 0, 1, 0, 31);

      begin
         int budget = 20;
         @(posedge clk);
         while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         #2;
         if (q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
